// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight destinations across STAGES stages and picks forward sources.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_scoreboard #(
  parameter  int AW       = 5,
  parameter  int NSRC     = 2,
  parameter  int STAGES   = 3,
  parameter  int LOAD_LAT = 2,
  localparam int SELW     = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic                 issue_wen,
  input  logic                 issue_is_load,
  input  logic [AW-1:0]        issue_dst,
  input  logic [NSRC*AW-1:0]   issue_src,
  input  logic [NSRC-1:0]      issue_src_use,
  input  logic                 hold_in,
  input  logic                 flush,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 lu_stall,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          fwd_cnt
);

  logic [STAGES:1] r_v;
  logic [STAGES:1] r_ld;
  logic [AW-1:0]   r_dst [1:STAGES];

  logic                 w_active;
  logic                 w_hit;
  logic [NSRC-1:0]      w_found;
  logic [NSRC-1:0]      w_rdy;
  logic [SELW-1:0]      w_win [NSRC];
  logic [NSRC*SELW-1:0] w_sel;
  logic                 w_stall;

  assign w_active = issue_valid & ~hold_in;

  // Youngest-producer search: scan oldest to youngest so the lowest stage index overwrites.
  always_comb begin
    w_hit   = 1'b0;
    w_found = '0;
    w_rdy   = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_win[i] = '0;
      for (int k = STAGES; k >= 1; k--) begin
        w_hit = issue_src_use[i] && r_v[k] &&
                (r_dst[k] == issue_src[i*AW +: AW]) &&
                (issue_src[i*AW +: AW] != '0);
        w_found[i] = w_hit ? 1'b1 : w_found[i];
        w_win[i]   = w_hit ? SELW'(k) : w_win[i];
        w_rdy[i]   = w_hit ? (!r_ld[k] || (k >= LOAD_LAT)) : w_rdy[i];
      end
    end
  end

  // A not-ready winner stalls and never falls back to an older ready producer.
  always_comb begin
    w_sel   = '0;
    w_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      w_sel[i*SELW +: SELW] = (w_active && w_found[i] && w_rdy[i]) ? w_win[i] : '0;
      w_stall = w_stall | (w_active && w_found[i] && !w_rdy[i]);
    end
  end

  assign fwd_sel  = w_sel;
  assign lu_stall = w_stall;

  // Producer pipe: flush kills everything, hold freezes, stall injects a bubble at stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v  <= '0;
      r_ld <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_dst[k] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else if (hold_in) begin
      r_v <= r_v;
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        r_v[k]   <= r_v[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_dst[k] <= r_dst[k-1];
      end
      if (w_stall) begin
        r_v[1]   <= 1'b0;
        r_ld[1]  <= 1'b0;
        r_dst[1] <= '0;
      end else begin
        r_v[1]   <= issue_valid & issue_wen & (issue_dst != '0);
        r_ld[1]  <= issue_is_load;
        r_dst[1] <= issue_dst;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_fwd_cnt;
  logic        w_fwd_issue;

  assign w_fwd_issue = w_active & ~w_stall & (|w_sel);

  // Saturating statistics; frozen and flushed cycles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
      r_fwd_cnt   <= 16'h0000;
    end else if (!flush && !hold_in) begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'h0001;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_fwd_issue && (r_fwd_cnt != 16'hFFFF)) begin
        r_fwd_cnt <= r_fwd_cnt + 16'h0001;
      end else begin
        r_fwd_cnt <= r_fwd_cnt;
      end
    end else begin
      r_stall_cnt <= r_stall_cnt;
      r_fwd_cnt   <= r_fwd_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`else
  assign stall_cnt = 16'h0000;
  assign fwd_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard at default parameters; expected values are hand-computed.
module tb_fwd_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_wen;
  logic        issue_is_load;
  logic [4:0]  issue_dst;
  logic [9:0]  issue_src;
  logic [1:0]  issue_src_use;
  logic        hold_in;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        lu_stall;
  logic [15:0] stall_cnt;
  logic [15:0] fwd_cnt;

  int n_vec = 0;
  int n_err = 0;

`ifdef FWD_STATS_EN
  localparam logic [15:0] EXP_STALLS = 16'd2;
  localparam logic [15:0] EXP_FWDS   = 16'd7;
`else
  localparam logic [15:0] EXP_STALLS = 16'd0;
  localparam logic [15:0] EXP_FWDS   = 16'd0;
`endif

  fwd_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_wen    (issue_wen),
    .issue_is_load(issue_is_load),
    .issue_dst    (issue_dst),
    .issue_src    (issue_src),
    .issue_src_use(issue_src_use),
    .hold_in      (hold_in),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .lu_stall     (lu_stall),
    .stall_cnt    (stall_cnt),
    .fwd_cnt      (fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wen, input logic ld, input logic [4:0] dst,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] use_);
    issue_valid   = v;
    issue_wen     = wen;
    issue_is_load = ld;
    issue_dst     = dst;
    issue_src     = {s1, s0};
    issue_src_use = use_;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Apply current inputs, check outputs at the falling edge, then commit at the rising edge.
  task automatic step(input string tag, input logic [3:0] exp_sel, input logic exp_stall);
    @(negedge clk);
    check({tag, ".sel"}, 32'(fwd_sel), 32'(exp_sel));
    check({tag, ".stall"}, 32'(lu_stall), 32'(exp_stall));
    tick();
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    hold_in = 1'b0;
    flush   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.sel", 32'(fwd_sel), 32'd0);
    check("reset.stall", 32'(lu_stall), 32'd0);
    check("reset.scnt", 32'(stall_cnt), 32'd0);
    check("reset.fcnt", 32'(fwd_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: ALU result forwarded from stage 1, then stage 2
    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 2'b11);  step("t1.add3", 4'b0000, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd3, 2'b11);  step("t1.add4", 4'b0101, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b01);  step("t1.rd3", 4'b0010, 1'b0);
    idle(3);

    // 2: load-use stall for one cycle, then forward from stage 2
    drive(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 2'b00);  step("t2.lw5", 4'b0000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01);  step("t2.stall", 4'b0000, 1'b1);
    step("t2.fwd", 4'b0010, 1'b0);
    idle(3);

    // 3: $0 never forwarded; youngest producer wins; unused source ignored
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);  step("t3.ori0", 4'b0000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11);  step("t3.rd0", 4'b0000, 1'b0);
    idle(3);
    drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00);  step("t3.add7a", 4'b0000, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00);  step("t3.add7b", 4'b0000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 2'b01);  step("t3.rd7", 4'b0001, 1'b0);
    idle(3);

    // 4: younger ready ALU producer shadows an older load
    drive(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 2'b00);  step("t4.lw6", 4'b0000, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 2'b00);  step("t4.add6", 4'b0000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 2'b01);  step("t4.rd6", 4'b0001, 1'b0);
    idle(3);

    // 4b: younger unready load stalls even though an older ready producer exists
    drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 2'b00); step("t4b.add10", 4'b0000, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 2'b00); step("t4b.lw10", 4'b0000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd10, 2'b10); step("t4b.stall", 4'b0000, 1'b1);
    step("t4b.fwd", 4'b1000, 1'b0);
    idle(3);

    // 5: hold freezes state and masks outputs; flush clears all stages
    drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0, 2'b00);  step("t5.add8", 4'b0000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 2'b01);
    hold_in = 1'b1;
    step("t5.hold1", 4'b0000, 1'b0);
    step("t5.hold2", 4'b0000, 1'b0);
    step("t5.hold3", 4'b0000, 1'b0);
    hold_in = 1'b0;
    step("t5.rel", 4'b0001, 1'b0);
    flush = 1'b1;
    step("t5.flush", 4'b0010, 1'b0);
    flush = 1'b0;
    step("t5.postflush", 4'b0000, 1'b0);
    idle(2);
    @(negedge clk);
    check("cnt.stall", 32'(stall_cnt), 32'(EXP_STALLS));
    check("cnt.fwd", 32'(fwd_cnt), 32'(EXP_FWDS));
    tick();

    // 6: async reset in the middle of a load-use stall
    drive(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00);  step("t6.lw9", 4'b0000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 2'b01);
    @(negedge clk);
    check("t6.prestall", 32'(lu_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6.rst.stall", 32'(lu_stall), 32'd0);
    check("t6.rst.sel", 32'(fwd_sel), 32'd0);
    check("t6.rst.scnt", 32'(stall_cnt), 32'd0);
    check("t6.rst.fcnt", 32'(fwd_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    step("t6.after", 4'b0000, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
